// File: rtl/dct_pkg.sv
// Shared types, widths and the cosine-table generator for the DCT coefficient engine.
package dct_pkg;

    localparam int DCT_N    = 8;
    localparam int DCT_FRAC = 8;
    localparam int KW       = $clog2(DCT_N);
    localparam int TERM_W   = DCT_FRAC + 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DRAIN = 2'd2,
        ST_OUT   = 2'd3
    } dct_state_e;

    // round(cos(m*pi/(2n)) * 2^frac) for 0 <= m <= n (first quadrant only, so result >= 0).
    // A Taylor series keeps this independent of any math system functions.
    function automatic int cos_q(input int m, input int n, input int frac);
        real x;
        real term;
        real sum;
        real scale;
        x     = m * 3.14159265358979323846 / (2.0 * n);
        term  = 1.0;
        sum   = 1.0;
        scale = 1.0;
        for (int i = 1; i <= 14; i++) begin
            term = -term * x * x / ((2.0 * i - 1.0) * (2.0 * i));
            sum  = sum + term;
        end
        for (int i = 0; i < frac; i++) begin
            scale = scale * 2.0;
        end
        return $rtoi(sum * scale + 0.5);
    endfunction

    // Quarter-wave table for the default block size.
    typedef int qwave_t [0:DCT_N];

    function automatic qwave_t gen_qwave();
        qwave_t q;
        for (int m = 0; m <= DCT_N; m++) begin
            q[m] = cos_q(m, DCT_N, DCT_FRAC);
        end
        return q;
    endfunction

    localparam qwave_t QWAVE = gen_qwave();

endpackage

// File: rtl/dct_cos_1d.sv
// Combinational 1D cosine term c(k,n) from a quarter-wave table plus cos symmetry.
module dct_cos_1d
    import dct_pkg::*;
#(
    parameter int N    = DCT_N,
    parameter int FRAC = DCT_FRAC
) (
    input  logic [$clog2(N)-1:0]        k,
    input  logic [$clog2(N)-1:0]        n,
    output logic signed [FRAC+1:0]      c
);

    localparam int KWID = $clog2(N);
    localparam int TW   = FRAC + 2;
    localparam int MW   = KWID + 2;   // m lives modulo 4N
    localparam logic [MW-1:0] QN  = MW'(N);
    localparam logic [MW-1:0] Q2N = MW'(2 * N);
    localparam logic [MW-1:0] Q3N = MW'(3 * N);

    logic signed [TW-1:0] qtab [0:N];

    for (genvar g = 0; g <= N; g++) begin : g_tab
        localparam logic signed [TW-1:0] V = TW'(cos_q(g, N, FRAC));
        assign qtab[g] = V;
    end

    logic [MW-1:0] m;
    logic [MW-1:0] idx;
    logic          neg;

    // Fold m onto the quarter wave: negate in (N,3N), mirror above 2N.
    always_comb begin
        m   = {1'b0, n, 1'b1} * {2'b00, k};
        idx = m;
        neg = 1'b0;
        if (m <= QN) begin
            idx = m;
            neg = 1'b0;
        end else if (m <= Q2N) begin
            idx = Q2N - m;
            neg = 1'b1;
        end else if (m < Q3N) begin
            idx = m - Q2N;
            neg = 1'b1;
        end else begin
            idx = MW'(0) - m;
            neg = 1'b0;
        end
        c = neg ? -qtab[idx[KWID:0]] : qtab[idx[KWID:0]];
    end

endmodule

// File: rtl/dct_coeff_engine.sv
// One 2D-DCT coefficient per N x N block for a run-time (k1,k2), three-stage MAC pipeline.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are both 1.
// valid never depends on ready; coef_data holds steady while coef_valid && !coef_ready.
module dct_coeff_engine
    import dct_pkg::*;
#(
    parameter int N     = DCT_N,
    parameter int FRAC  = DCT_FRAC,
    parameter int PIX_W = 9,
    parameter int ACC_W = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [$clog2(N)-1:0]     k1,
    input  logic [$clog2(N)-1:0]     k2,
    output logic                     busy,
    input  logic                     pix_valid,
    output logic                     pix_ready,
    input  logic signed [PIX_W-1:0]  pix_data,
    output logic                     coef_valid,
    input  logic                     coef_ready,
    output logic signed [ACC_W-1:0]  coef_data,
    output dct_state_e               dbg_state
);

    localparam int KWID = $clog2(N);
    localparam int TW   = FRAC + 2;
    localparam int PW   = 2 * TW;
    localparam logic [KWID-1:0]        LAST = KWID'(N - 1);
    localparam logic signed [PW-1:0]   RND  = PW'((1 << FRAC) - 1);

    dct_state_e state, state_nx;

    logic [KWID-1:0]         k1_q, k2_q, n1, n2;
    logic                    s1_v, s2_v;
    logic signed [TW-1:0]    c1, c2, s1_c1, s1_c2, s2_t, t_nx;
    logic signed [PIX_W-1:0] s1_pix, s2_pix;
    logic signed [ACC_W-1:0] acc, mac;
    logic signed [PW-1:0]    prod, prod_adj;
    logic                    accept, last_pix, take_start;

    dct_cos_1d #(.N(N), .FRAC(FRAC)) u_cos_row (.k(k1_q), .n(n1), .c(c1));
    dct_cos_1d #(.N(N), .FRAC(FRAC)) u_cos_col (.k(k2_q), .n(n2), .c(c2));

    assign accept     = pix_valid && pix_ready;
    assign last_pix   = accept && (n1 == LAST) && (n2 == LAST);
    assign take_start = (state == ST_IDLE) && start;

    // Product of the 1D terms, truncated toward zero so t(-x) = -t(x); then the MAC term.
    always_comb begin
        prod     = s1_c1 * s1_c2;
        prod_adj = prod[PW-1] ? prod + RND : prod;
        t_nx     = TW'(prod_adj >>> FRAC);
        mac      = ACC_W'(s2_pix) * ACC_W'(s2_t);
    end

    // Next state and stream-side outputs.
    always_comb begin
        state_nx   = state;
        pix_ready  = 1'b0;
        coef_valid = 1'b0;
        busy       = (state != ST_IDLE);
        case (state)
            ST_IDLE:  if (start) state_nx = ST_ACCUM;
            ST_ACCUM: begin
                pix_ready = 1'b1;
                if (last_pix) state_nx = ST_DRAIN;
            end
            ST_DRAIN: if (!s1_v && !s2_v) state_nx = ST_OUT;
            ST_OUT: begin
                coef_valid = 1'b1;
                if (coef_ready) state_nx = ST_IDLE;
            end
            default:  state_nx = ST_IDLE;
        endcase
    end

    assign coef_data = acc;
    assign dbg_state = state;

    // State register, frequency latch and raster counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            k1_q  <= '0;
            k2_q  <= '0;
            n1    <= '0;
            n2    <= '0;
        end else begin
            state <= state_nx;
            if (take_start) begin
                k1_q <= k1;
                k2_q <= k2;
                n1   <= '0;
                n2   <= '0;
            end else if (accept) begin
                if (n2 == LAST) begin
                    n2 <= '0;
                    n1 <= n1 + 1'b1;
                end else begin
                    n2 <= n2 + 1'b1;
                end
            end
        end
    end

    // Pipeline S1 (1D lookups + pixel), S2 (2D term + pixel), S3 (accumulate); valids carry bubbles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v   <= 1'b0;
            s1_c1  <= '0;
            s1_c2  <= '0;
            s1_pix <= '0;
            s2_v   <= 1'b0;
            s2_t   <= '0;
            s2_pix <= '0;
            acc    <= '0;
        end else begin
            s1_v   <= accept;
            s1_c1  <= c1;
            s1_c2  <= c2;
            s1_pix <= pix_data;
            s2_v   <= s1_v;
            s2_t   <= t_nx;
            s2_pix <= s1_pix;
            if (take_start) begin
                acc <= '0;
            end else if (s2_v) begin
                acc <= acc + mac;
            end
        end
    end

endmodule

// File: tb/tb_dct_coeff_engine.sv
// Directed bench for dct_coeff_engine with an independent floating-point cosine model.
module tb_dct_coeff_engine;
    import dct_pkg::*;

    localparam real PI = 3.14159265358979323846;

    logic               clk;
    logic               rst_n;
    logic               start;
    logic [2:0]         k1, k2;
    logic               busy;
    logic               pix_valid;
    logic               pix_ready;
    logic signed [8:0]  pix_data;
    logic               coef_valid;
    logic               coef_ready;
    logic signed [31:0] coef_data;
    dct_state_e         dbg_state;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int pix_mem [64];

    dct_coeff_engine #(.N(8), .FRAC(8), .PIX_W(9), .ACC_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .k1(k1), .k2(k2), .busy(busy),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
        .coef_valid(coef_valid), .coef_ready(coef_ready), .coef_data(coef_data),
        .dbg_state(dbg_state)
    );

    // Clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model.
    function automatic int c_ref(input int k, input int n);
        real v;
        v = $cos((2.0 * n + 1.0) * k * PI / 16.0) * 256.0;
        return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(-v + 0.5);
    endfunction

    function automatic int ref_coef(input int a, input int b);
        int s;
        s = 0;
        for (int r = 0; r < 8; r++)
            for (int q = 0; q < 8; q++)
                s += pix_mem[r * 8 + q] * ((c_ref(a, r) * c_ref(b, q)) / 256);
        return s;
    endfunction

    // Drivers.
    task automatic apply_reset();
        rst_n = 1'b0; start = 1'b0; k1 = '0; k2 = '0;
        pix_valid = 1'b0; pix_data = '0; coef_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic do_start(input int a, input int b);
        k1 = 3'(a); k2 = 3'(b); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Streams pix_mem[0..count-1]; poke >= 0 raises start on that pixel index.
    task automatic feed(input bit bubbles, input int count, input int poke, output bit ok);
        int idx;
        int guard;
        idx = 0; guard = 0;
        while (idx < count && guard < 1000) begin
            pix_valid = bubbles ? 1'($urandom_range(0, 1)) : 1'b1;
            pix_data  = 9'(pix_mem[idx]);
            start     = (idx == poke);
            if (start) begin k1 = 3'd5; k2 = 3'd6; end
            if (pix_valid && pix_ready) idx++;
            @(posedge clk); #1;
            guard++;
        end
        pix_valid = 1'b0;
        start = 1'b0;
        ok = (idx == count);
    endtask

    task automatic wait_valid(output int edges);
        edges = 0;
        while (!coef_valid && edges < 40) begin
            @(posedge clk); #1;
            edges++;
        end
    endtask

    task automatic run_coef(input int a, input int b, input bit bubbles,
                            output logic signed [31:0] val, output int edges);
        bit ok;
        do_start(a, b);
        feed(bubbles, 64, -1, ok);
        wait_valid(edges);
        val = coef_data;
        coef_ready = 1'b1;
        @(posedge clk); #1;
        coef_ready = 1'b0;
        total_cnt++;
        if (!ok || !(edges < 40)) $display("FAIL run_handshake k=(%0d,%0d): fed=%0d edges=%0d, required full block and coef_valid", a, b, ok, edges);
        else pass_cnt++;
    endtask

    task automatic fill_const(input int v);
        for (int i = 0; i < 64; i++) pix_mem[i] = v;
    endtask

    // Tests.
    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; pix_valid = 1'b0; coef_ready = 1'b0;
        k1 = '0; k2 = '0; pix_data = '0;
        #1;
        total_cnt++; if (busy !== 1'b0)       $display("FAIL reset_busy: got %b want 0", busy);            else pass_cnt++;
        total_cnt++; if (pix_ready !== 1'b0)  $display("FAIL reset_pix_ready: got %b want 0", pix_ready);  else pass_cnt++;
        total_cnt++; if (coef_valid !== 1'b0) $display("FAIL reset_coef_valid: got %b want 0", coef_valid); else pass_cnt++;
        total_cnt++; if (coef_data !== 32'sd0) $display("FAIL reset_coef_data: got %0d want 0", coef_data); else pass_cnt++;
        total_cnt++; if (dbg_state !== ST_IDLE) $display("FAIL reset_state: got %0d want %0d", dbg_state, ST_IDLE); else pass_cnt++;
        apply_reset();
    endtask

    task automatic test_dc();
        logic signed [31:0] v;
        int e;
        fill_const(1);
        run_coef(0, 0, 1'b0, v, e);
        total_cnt++; if (v !== 32'sd16384) $display("FAIL dc_value: got %0d want 16384", v); else pass_cnt++;
        total_cnt++; if (e !== 3) $display("FAIL dc_latency: got %0d edges want 3", e); else pass_cnt++;
    endtask

    task automatic test_impulse_sweep();
        logic signed [31:0] v;
        int e;
        fill_const(0);
        pix_mem[0] = 1;
        for (int a = 0; a < 8; a++) begin
            for (int b = 0; b < 8; b++) begin
                run_coef(a, b, 1'b0, v, e);
                total_cnt++;
                if (v !== 32'(ref_coef(a, b))) $display("FAIL impulse k=(%0d,%0d): got %0d want %0d", a, b, v, ref_coef(a, b));
                else pass_cnt++;
                if (a == 1 && b == 7) begin
                    total_cnt++; if (v !== 32'sd49) $display("FAIL impulse_1_7: got %0d want 49", v); else pass_cnt++;
                end
            end
        end
    endtask

    task automatic test_odd_symmetry();
        logic signed [31:0] v;
        int e;
        fill_const(1);
        run_coef(1, 7, 1'b0, v, e);
        total_cnt++; if (v !== 32'sd0) $display("FAIL odd_symmetry: got %0d want 0", v); else pass_cnt++;
    endtask

    task automatic test_bubbles();
        logic signed [31:0] v0, v1;
        int e0, e1, exp_v;
        for (int i = 0; i < 64; i++) pix_mem[i] = int'($urandom_range(0, 511)) - 256;
        exp_v = ref_coef(2, 5);
        run_coef(2, 5, 1'b0, v0, e0);
        run_coef(2, 5, 1'b1, v1, e1);
        total_cnt++; if (v0 !== 32'(exp_v)) $display("FAIL nobubble_value: got %0d want %0d", v0, exp_v); else pass_cnt++;
        total_cnt++; if (v1 !== 32'(exp_v)) $display("FAIL bubble_value: got %0d want %0d", v1, exp_v); else pass_cnt++;
        total_cnt++; if (e1 !== 3) $display("FAIL bubble_latency: got %0d edges want 3", e1); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic signed [31:0] v;
        int e, exp_v;
        bit ok;
        for (int i = 0; i < 64; i++) pix_mem[i] = int'($urandom_range(0, 511)) - 256;
        exp_v = ref_coef(3, 1);
        do_start(3, 1);
        feed(1'b0, 64, 10, ok);
        wait_valid(e);
        total_cnt++; if (!ok || e !== 3) $display("FAIL bp_reach_out: fed=%0d edges=%0d want 1/3", ok, e); else pass_cnt++;
        for (int c = 0; c < 5; c++) begin
            total_cnt++;
            if (coef_valid !== 1'b1 || coef_data !== 32'(exp_v))
                $display("FAIL bp_hold cyc%0d: valid=%b data=%0d want 1/%0d", c, coef_valid, coef_data, exp_v);
            else pass_cnt++;
            @(posedge clk); #1;
        end
        // Start alongside the handshake is ignored; the one after it is honoured.
        k1 = 3'd1; k2 = 3'd7; start = 1'b1; coef_ready = 1'b1;
        @(posedge clk); #1;
        coef_ready = 1'b0;
        total_cnt++; if (busy !== 1'b0) $display("FAIL start_at_handshake: busy=%b want 0", busy); else pass_cnt++;
        k1 = 3'd0; k2 = 3'd0;
        @(posedge clk); #1;
        start = 1'b0;
        total_cnt++; if (busy !== 1'b1) $display("FAIL start_after_handshake: busy=%b want 1", busy); else pass_cnt++;
        feed(1'b0, 64, -1, ok);
        wait_valid(e);
        v = coef_data;
        coef_ready = 1'b1;
        @(posedge clk); #1;
        coef_ready = 1'b0;
        total_cnt++; if (v !== 32'(ref_coef(0, 0))) $display("FAIL restart_value: got %0d want %0d", v, ref_coef(0, 0)); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        logic signed [31:0] v;
        int e;
        bit ok;
        fill_const(1);
        do_start(0, 0);
        feed(1'b0, 20, -1, ok);
        pix_valid = 1'b1;
        @(posedge clk); @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        total_cnt++; if (busy !== 1'b0)        $display("FAIL midreset_busy: got %b want 0", busy);          else pass_cnt++;
        total_cnt++; if (pix_ready !== 1'b0)   $display("FAIL midreset_pix_ready: got %b want 0", pix_ready); else pass_cnt++;
        total_cnt++; if (coef_valid !== 1'b0)  $display("FAIL midreset_coef_valid: got %b want 0", coef_valid); else pass_cnt++;
        total_cnt++; if (coef_data !== 32'sd0) $display("FAIL midreset_coef_data: got %0d want 0", coef_data); else pass_cnt++;
        pix_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_coef(0, 0, 1'b0, v, e);
        total_cnt++; if (v !== 32'sd16384) $display("FAIL post_reset_dc: got %0d want 16384", v); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_dc();
        test_impulse_sweep();
        test_odd_symmetry();
        test_bubbles();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
